i2c_cmd_arbiter: RTL and testbench

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2c_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/i2c_cmd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// ----------------------------------------------------------------------------
// i2c_arb_pkg
// Shared types and sizes for the I2C command arbiter.
//   ADDR_W  : I2C slave address width (7)
//   DATA_W  : register / data byte width (8)
//   NREQ    : number of requesters (2)
//   state_e : arbiter transaction state
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int NREQ   = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      DATA  = 3'd3,
      CAPT  = 3'd4,
      CLEAN = 3'd5,
      DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req_valid [1:0] in  : pending requests
//   ptr             in  : preferred requester when both are pending
//   gnt       [1:0] out : one-hot grant (0 when nothing pending)
//   gnt_idx         out : index of the granted requester
//   gnt_any         out : at least one request pending
// ----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       gnt_idx,
   output logic       gnt_any
);

   always_comb begin
      gnt_idx = 1'b0;
      gnt     = 2'b00;
      gnt_any = |req_valid;
      case (req_valid)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ptr;
         default: gnt_idx = 1'b0;
      endcase
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_cmd_arbiter
// Arbitrates single-byte I2C commands from two requesters onto one I2C master.
// Each transaction: START pulse, wait for address ack, wait for data ack,
// capture the read byte, hold the master in reset for two cycles, report done.
//
// Optional feature macro: I2C_CMD_ARB_TIMEOUT_EN
//   defined   -> watchdog aborts ADDR/DATA after TIMEOUT_CYCLES, err=1 on done
//   undefined -> no watchdog, err tied 0, ADDR/DATA wait indefinitely
//
// Ports
//   clk, reset (async, active-low)
//   req_valid/req_addr/req_reg/req_mode : per-requester command inputs
//   req_grant  : one-cycle grant pulse (command latched that cycle)
//   req_done   : one-cycle completion pulse, qualified by err
//   rdata      : last captured read byte
//   m_address/m_register/m_mode/m_en/m_start/m_stop/m_rst_n : master command
//   m_ack, m_out : master ack pulse and read byte
// ----------------------------------------------------------------------------
module i2c_cmd_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_reg,
   input  logic [NREQ-1:0]        req_mode,
   output logic [NREQ-1:0]        req_grant,
   output logic [NREQ-1:0]        req_done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   err,
   output logic [ADDR_W-1:0]      m_address,
   output logic [DATA_W-1:0]      m_register,
   output logic                   m_mode,
   output logic                   m_en,
   output logic                   m_start,
   output logic                   m_stop,
   output logic                   m_rst_n,
   input  logic                   m_ack,
   input  logic [DATA_W-1:0]      m_out
);

   state_e              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   reg_q, reg_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                clean_q, clean_d;
   // Goes high on the first edge after reset release; keeps the master in
   // reset and blocks grants until then.
   logic                live_q, live_d;

   logic [1:0]          arb_gnt;
   logic                arb_idx;
   logic                arb_any;
   logic                grant_fire;
   logic                timeout_hit;
   logic                busy;

   rr_arb2 u_rr_arb2 (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_any   (arb_any)
   );

   assign grant_fire = (state_q == IDLE) && live_q && arb_any;

`ifdef I2C_CMD_ARB_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

   logic [9:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   // Watchdog counts every ADDR/DATA cycle; an ack in the final cycle wins.
   always_comb begin
      cnt_d       = cnt_q;
      err_d       = err_q;
      timeout_hit = 1'b0;
      if (state_q == START) begin
         cnt_d = '0;
      end else if ((state_q == ADDR) || (state_q == DATA)) begin
         cnt_d       = cnt_q + 10'd1;
         timeout_hit = !m_ack && (cnt_q == TO_LAST);
      end
      if (grant_fire) begin
         err_d = 1'b0;
      end else if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = (state_q == DONE) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      reg_d     = reg_q;
      mode_d    = mode_q;
      rdata_d   = rdata_q;
      clean_d   = 1'b0;
      live_d    = 1'b1;
      req_grant = '0;
      req_done  = '0;
      m_en      = 1'b0;
      m_start   = 1'b0;
      m_stop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_fire) begin
               req_grant = arb_gnt;
               idx_d     = arb_idx;
               addr_d    = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
               reg_d     = req_reg[int'(arb_idx)*DATA_W +: DATA_W];
               mode_d    = req_mode[arb_idx];
               state_d   = START;
            end
         end
         START: begin
            m_en    = 1'b1;
            m_start = 1'b1;
            m_stop  = 1'b1;
            state_d = ADDR;
         end
         ADDR: begin
            m_stop = 1'b1;
            if (m_ack) begin
               state_d = DATA;
            end else if (timeout_hit) begin
               state_d = CLEAN;
            end
         end
         DATA: begin
            m_stop = 1'b1;
            if (m_ack) begin
               state_d = CAPT;
            end else if (timeout_hit) begin
               state_d = CLEAN;
            end
         end
         CAPT: begin
            m_stop = 1'b1;
            if (mode_q) begin
               rdata_d = m_out;
            end
            state_d = CLEAN;
         end
         CLEAN: begin
            // clean_q marks the second of the two master-reset cycles.
            clean_d = !clean_q;
            if (clean_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            req_done[idx_q] = 1'b1;
            ptr_d           = ~idx_q;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q == START) || (state_q == ADDR) || (state_q == DATA) ||
                       (state_q == CAPT)  || (state_q == CLEAN);
   assign m_address  = busy ? addr_q : '0;
   assign m_register = busy ? reg_q  : '0;
   assign m_mode     = busy && mode_q;
   assign m_rst_n    = live_q && (state_q != CLEAN);
   assign rdata      = rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         idx_q   <= 1'b0;
         rdata_q <= '0;
         clean_q <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         clean_q <= clean_d;
         live_q  <= live_d;
      end
   end

   // Latched command; only visible through the busy-gated outputs.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      reg_q  <= reg_d;
      mode_q <= mode_d;
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_arbiter
// Randomized bench for i2c_cmd_arbiter with a transaction-level reference
// model (round-robin pointer, expected read byte, done latency after the
// data ack). Optional watchdog scenario under I2C_CMD_ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_i2c_cmd_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [13:0] req_addr;
   logic [15:0] req_reg;
   logic [1:0]  req_mode;
   logic [1:0]  req_grant;
   logic [1:0]  req_done;
   logic [7:0]  rdata;
   logic        err;
   logic [6:0]  m_address;
   logic [7:0]  m_register;
   logic        m_mode;
   logic        m_en;
   logic        m_start;
   logic        m_stop;
   logic        m_rst_n;
   logic        m_ack;
   logic [7:0]  m_out;

   int          checks   = 0;
   int          failures = 0;
   logic        ptr_m;
   logic [7:0]  rdata_m;

   i2c_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_reg    (req_reg),
      .req_mode   (req_mode),
      .req_grant  (req_grant),
      .req_done   (req_done),
      .rdata      (rdata),
      .err        (err),
      .m_address  (m_address),
      .m_register (m_register),
      .m_mode     (m_mode),
      .m_en       (m_en),
      .m_start    (m_start),
      .m_stop     (m_stop),
      .m_rst_n    (m_rst_n),
      .m_ack      (m_ack),
      .m_out      (m_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=hang exp=finish");
      $fatal(1, "bench timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {7'd0, req_grant, req_done, err, m_address, m_register,
              m_mode, m_en, m_start, m_stop, m_rst_n};
   endfunction

   // One complete transaction; expectations come from the round-robin rule
   // and the fixed post-ack sequence (capture, two reset cycles, done).
   task automatic do_txn(input logic [1:0] vmask, input logic [13:0] a, input logic [15:0] r,
                         input logic [1:0] md, input int d1, input int d2,
                         input logic [7:0] mo, input logic drop);
      int         idx;
      logic [6:0] ea;
      logic [7:0] er;
      logic       em;
      int         n;
      int         lows;
      logic       seen;
      @(negedge clk);
      req_valid = vmask; req_addr = a; req_reg = r; req_mode = md; m_ack = 1'b0;
      #1;
      idx = (vmask == 2'b11) ? int'(ptr_m) : (vmask[1] ? 1 : 0);
      ea  = a[7*idx +: 7];
      er  = r[8*idx +: 8];
      em  = md[idx];
      check_eq("grant", 32'(req_grant), 32'(1) << idx);
      // START: scramble inputs to prove the command was latched
      @(negedge clk);
      req_addr = 14'($urandom); req_reg = 16'($urandom); req_mode = 2'($urandom);
      if (drop) req_valid = 2'b00;
      #1;
      check_eq("start_pulse", {28'd0, m_start, m_en, m_stop, m_rst_n}, 32'hF);
      check_eq("start_addr", 32'(m_address), 32'(ea));
      check_eq("start_reg", 32'(m_register), 32'(er));
      check_eq("start_mode", 32'(m_mode), 32'(em));
      check_eq("start_grant_low", 32'(req_grant), 32'd0);
      repeat (d1) begin
         @(negedge clk); m_ack = 1'b0; #1;
         check_eq("addr_hold", {m_address, m_register, m_mode, m_stop, m_start}, {ea, er, em, 2'b10});
      end
      @(negedge clk); m_ack = 1'b1; #1;
      repeat (d2) begin
         @(negedge clk); m_ack = 1'b0; #1;
         check_eq("data_hold", {m_address, m_register, m_mode, m_stop, m_en}, {ea, er, em, 2'b10});
      end
      @(negedge clk); m_ack = 1'b1; m_out = mo; #1;
      @(negedge clk); m_ack = 1'b0; #1;
      check_eq("capt_stop_rst", {30'd0, m_stop, m_rst_n}, 32'h3);
      n = 1; lows = 0; seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); m_ack = 1'($urandom); #1;
         n++;
         if (!m_rst_n) begin
            lows++;
            check_eq("clean_hold", {m_address, m_register, m_mode, m_stop}, {ea, er, em, 1'b0});
         end
         if (req_done != 2'b00) begin
            seen = 1'b1;
            break;
         end
      end
      m_ack = 1'b0;
      check_eq("done_seen", 32'(seen), 32'd1);
      if (seen) begin
         if (em) rdata_m = mo;
         check_eq("done_latency", 32'(n), 32'd4);
         check_eq("done_vec", 32'(req_done), 32'(1) << idx);
         check_eq("done_err", 32'(err), 32'd0);
         check_eq("done_rdata", 32'(rdata), 32'(rdata_m));
         ptr_m = (idx == 0);
      end
      check_eq("clean_len", 32'(lows), 32'd2);
      @(negedge clk); req_valid = 2'b00; #1;
      check_eq("idle_outs", {req_done, m_address, m_register, m_mode, m_stop, m_rst_n},
               {2'b00, 7'd0, 8'd0, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      reset = 1'b0; req_valid = 2'b11; req_addr = '0; req_reg = '0; req_mode = '0;
      m_ack = 1'b0; m_out = '0; ptr_m = 1'b0; rdata_m = 8'd0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_outs", all_outs(), 32'd0);
      check_eq("reset_rdata", 32'(rdata), 32'd0);
      req_valid = 2'b00;
      @(negedge clk); reset = 1'b1; #1;
      check_eq("mrst_before_edge", 32'(m_rst_n), 32'd0);
      @(negedge clk); #1;
      check_eq("mrst_after_edge", 32'(m_rst_n), 32'd1);

      // Single read from requester 0
      do_txn(2'b01, {7'h11, 7'h48}, 16'h3377, 2'b01, 9, 9, 8'hA5, 1'b0);
      // Write from requester 1
      do_txn(2'b10, {7'h3C, 7'h05}, {8'h5A, 8'h99}, 2'b00, 2, 3, 8'hC3, 1'b1);
      // Contention: pointer alternates 0,1,0
      do_txn(2'b11, 14'($urandom), 16'($urandom), 2'b11, 1, 1, 8'h3E, 1'b0);
      do_txn(2'b11, 14'($urandom), 16'($urandom), 2'b11, 0, 0, 8'h71, 1'b0);
      do_txn(2'b11, 14'($urandom), 16'($urandom), 2'b00, 3, 0, 8'h0F, 1'b0);

      for (int t = 0; t < 25; t++) begin
         do_txn(2'($urandom_range(1, 3)), 14'($urandom), 16'($urandom), 2'($urandom),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                8'($urandom), 1'($urandom));
      end

      // Reset during DATA
      @(negedge clk); req_valid = 2'b01; req_addr = 14'h0022; req_mode = 2'b01; #1;
      check_eq("rst_txn_grant", 32'(req_grant), 32'd1);
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); m_ack = 1'b1;
      @(negedge clk); m_ack = 1'b0; #1;
      check_eq("pre_rst_stop", 32'(m_stop), 32'd1);
      #2; reset = 1'b0; #1;
      check_eq("midrst_outs", all_outs(), 32'd0);
      check_eq("midrst_rdata", 32'(rdata), 32'd0);
      rdata_m = 8'd0; ptr_m = 1'b0;
      req_valid = 2'b11;
      repeat (3) begin
         @(negedge clk); #1;
         check_eq("inrst_quiet", {30'd0, req_grant | req_done}, 32'd0);
      end
      req_valid = 2'b00;
      @(negedge clk); reset = 1'b1; #1;
      check_eq("rel_mrst_low", 32'(m_rst_n), 32'd0);
      check_eq("rel_no_done", 32'(req_done), 32'd0);
      @(negedge clk); #1;
      check_eq("rel_mrst_high", 32'(m_rst_n), 32'd1);
      do_txn(2'b11, 14'($urandom), 16'($urandom), 2'b01, 1, 2, 8'h5C, 1'b0);

`ifdef I2C_CMD_ARB_TIMEOUT_EN
      begin
         int   n;
         logic seen;
         @(negedge clk); req_valid = 2'b01; req_addr = 14'h0033; req_mode = 2'b01; m_out = 8'hEE; #1;
         check_eq("to_grant", 32'(req_grant), 32'd1);
         @(negedge clk); req_valid = 2'b00; #1;
         check_eq("to_start", 32'(m_start), 32'd1);
         n = 0; seen = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            n++;
            if (req_done != 2'b00) begin
               seen = 1'b1;
               break;
            end
         end
         check_eq("to_seen", 32'(seen), 32'd1);
         check_eq("to_latency", 32'(n), 32'(TO + 3));
         check_eq("to_done", 32'(req_done), 32'd1);
         check_eq("to_err", 32'(err), 32'd1);
         check_eq("to_rdata", 32'(rdata), 32'(rdata_m));
         ptr_m = 1'b1;
         @(negedge clk); #1;
         check_eq("to_err_clr", 32'(err), 32'd0);
         do_txn(2'b11, 14'($urandom), 16'($urandom), 2'b01, 0, 1, 8'h42, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
